// File: rtl/rotary_dial_decoder.sv
// Rotary dial front end: synchronizes and debounces the quadrature contacts,
// tracks detents, and turns them into a wrapping position plus a direction flag.
module rotary_dial_decoder #(
    parameter int unsigned MAX_COUNT       = 19,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       ResetN,
    input  logic       RotA,
    input  logic       RotB,
    input  logic       Clear,
    output logic [4:0] Count,
    output logic       Right,
    output logic       Left,
    output logic       Step
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0] MAX_C = 5'(MAX_COUNT);

    typedef enum logic [2:0] {
        ST_REST, ST_R1, ST_R2, ST_R3, ST_L1, ST_L2, ST_L3
    } state_t;

    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            acc_q, acc_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    state_t                state_q, state_d;
    logic [4:0]            count_q, count_d;
    logic                  right_q, right_d;
    logic                  left_q, left_d;
    logic                  step_q, step_d;
    logic                  det_r_c, det_l_c;

    // Two-flop synchronizer, then per-contact debounce on the synchronized level
    always_comb begin
        sync1_d = {RotA, RotB};
        sync2_d = sync1_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == acc_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                acc_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            acc_q   <= 2'b11;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= ST_REST;
        end else begin
            state_q <= state_d;
        end
    end

    // Detent tracker; any illegal code drops back to REST
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_REST: begin
                if (acc_q == 2'b01)      state_d = ST_R1;
                else if (acc_q == 2'b10) state_d = ST_L1;
            end
            ST_R1: begin
                if (acc_q == 2'b00)      state_d = ST_R2;
                else if (acc_q != 2'b01) state_d = ST_REST;
            end
            ST_R2: begin
                if (acc_q == 2'b10)      state_d = ST_R3;
                else if (acc_q == 2'b01) state_d = ST_R1;
                else if (acc_q == 2'b11) state_d = ST_REST;
            end
            ST_R3: begin
                if (acc_q == 2'b00)      state_d = ST_R2;
                else if (acc_q != 2'b10) state_d = ST_REST;
            end
            ST_L1: begin
                if (acc_q == 2'b00)      state_d = ST_L2;
                else if (acc_q != 2'b10) state_d = ST_REST;
            end
            ST_L2: begin
                if (acc_q == 2'b01)      state_d = ST_L3;
                else if (acc_q == 2'b10) state_d = ST_L1;
                else if (acc_q == 2'b11) state_d = ST_REST;
            end
            ST_L3: begin
                if (acc_q == 2'b00)      state_d = ST_L2;
                else if (acc_q != 2'b01) state_d = ST_REST;
            end
            default: state_d = ST_REST;
        endcase
    end

    always_comb begin
        det_r_c = (state_q == ST_R3) && (acc_q == 2'b11);
        det_l_c = (state_q == ST_L3) && (acc_q == 2'b11);
    end

    // A reversal detent only flips the direction flags; Count holds the dialled number
    always_comb begin
        count_d = count_q;
        right_d = right_q;
        left_d  = left_q;
        step_d  = 1'b0;
        if (Clear) begin
            count_d = '0;
            right_d = 1'b0;
            left_d  = 1'b0;
        end else if (det_r_c) begin
            step_d  = 1'b1;
            right_d = 1'b1;
            left_d  = 1'b0;
            if (!left_q) count_d = (count_q == MAX_C) ? 5'd0 : count_q + 5'd1;
        end else if (det_l_c) begin
            step_d  = 1'b1;
            left_d  = 1'b1;
            right_d = 1'b0;
            if (!right_q) count_d = (count_q == 5'd0) ? MAX_C : count_q - 5'd1;
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            count_q <= '0;
            right_q <= 1'b0;
            left_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            right_q <= right_d;
            left_q  <= left_d;
            step_q  <= step_d;
        end
    end

    assign Count = count_q;
    assign Right = right_q;
    assign Left  = left_q;
    assign Step  = step_q;

endmodule

// File: tb/tb_rotary_dial_decoder.sv
// Bench for rotary_dial_decoder: directed scenarios plus a random dial walk
// checked against a gray-code displacement model of the detent rules.
module tb_rotary_dial_decoder;

    localparam int D    = 4;
    localparam int MAXC = 19;
    localparam int LONG = D + 4;

    logic       Clk = 1'b0;
    logic       ResetN, RotA, RotB, Clear;
    logic [4:0] Count;
    logic       Right, Left, Step;

    int tests = 0;
    int fails = 0;
    int step_seen = 0;
    int both_seen = 0;

    // model: last accepted level, displacement from rest in quarter-steps
    logic [1:0] m_lvl;
    int m_off, m_cnt, m_steps;
    logic m_r, m_l;

    rotary_dial_decoder #(.MAX_COUNT(MAXC), .DEBOUNCE_CYCLES(D)) dut (
        .Clk(Clk), .ResetN(ResetN), .RotA(RotA), .RotB(RotB), .Clear(Clear),
        .Count(Count), .Right(Right), .Left(Left), .Step(Step)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (Step) step_seen++;
        if (Right && Left) both_seen++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int gidx(input logic [1:0] ab);
        case (ab)
            2'b11: return 0;
            2'b01: return 1;
            2'b00: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] lvl_of(input int g);
        case (g % 4)
            0: return 2'b11;
            1: return 2'b01;
            2: return 2'b00;
            default: return 2'b10;
        endcase
    endfunction

    function automatic int off_of(input logic [1:0] ab);
        if (ab == 2'b01) return 1;
        if (ab == 2'b10) return -1;
        return 0;
    endfunction

    task automatic model_reset();
        m_lvl = 2'b11; m_off = 0; m_cnt = 0; m_r = 1'b0; m_l = 1'b0;
    endtask

    task automatic model_apply(input logic [1:0] lvl);
        int d;
        if (lvl == m_lvl) return;
        d = (gidx(lvl) - gidx(m_lvl) + 4) % 4;
        if (m_off == 0 || d == 2) m_off = off_of(lvl);
        else if (d == 1) m_off = m_off + 1;
        else m_off = m_off - 1;
        m_lvl = lvl;
        if (m_off == 4) begin
            m_off = 0; m_steps++;
            if (!m_l) m_cnt = (m_cnt == MAXC) ? 0 : m_cnt + 1;
            m_r = 1'b1; m_l = 1'b0;
        end else if (m_off == -4) begin
            m_off = 0; m_steps++;
            if (!m_r) m_cnt = (m_cnt == 0) ? MAXC : m_cnt - 1;
            m_l = 1'b1; m_r = 1'b0;
        end
    endtask

    // hold a raw level; holds shorter than D are bounces and must return to the accepted level
    task automatic drive(input logic [1:0] lvl, input int hold);
        {RotA, RotB} = lvl;
        repeat (hold) @(posedge Clk);
        #1;
        if (hold >= D) model_apply(lvl);
    endtask

    task automatic cw();
        drive(2'b01, LONG); drive(2'b00, LONG); drive(2'b10, LONG); drive(2'b11, LONG);
    endtask

    task automatic ccw();
        drive(2'b10, LONG); drive(2'b00, LONG); drive(2'b01, LONG); drive(2'b11, LONG);
    endtask

    task automatic do_reset();
        ResetN = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        ResetN = 1'b1;
        model_reset();
        m_steps = step_seen;
    endtask

    task automatic test_reset();
        #2 ResetN = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        tests++; if (Count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", Count); end
        tests++; if (Right !== 1'b0) begin fails++; $display("FAIL reset_right: got %b want 0", Right); end
        tests++; if (Left !== 1'b0) begin fails++; $display("FAIL reset_left: got %b want 0", Left); end
        tests++; if (Step !== 1'b0) begin fails++; $display("FAIL reset_step: got %b want 0", Step); end
        ResetN = 1'b1;
        model_reset();
        m_steps = 0;
    endtask

    task automatic test_cw_latency();
        int s0, lat;
        drive(2'b01, 10); drive(2'b00, 10); drive(2'b10, 10);
        s0 = step_seen; lat = -1;
        {RotA, RotB} = 2'b11;
        for (int i = 1; i <= 20; i++) begin
            @(posedge Clk); #1;
            if (Step === 1'b1 && lat < 0) lat = i;
        end
        model_apply(2'b11);
        tests++; if (lat != 7) begin fails++; $display("FAIL cw_step_latency: got %0d want 7", lat); end
        tests++; if (step_seen - s0 != 1) begin fails++; $display("FAIL cw_step_pulses: got %0d want 1", step_seen - s0); end
        tests++; if (Count !== 5'd1) begin fails++; $display("FAIL cw_count: got %0d want 1", Count); end
        tests++; if (Right !== 1'b1 || Left !== 1'b0) begin fails++; $display("FAIL cw_flags: got R%b L%b want R1 L0", Right, Left); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 18; i++) cw();
        tests++; if (Count !== 5'd19 || Right !== 1'b1) begin fails++; $display("FAIL wrap_at_max: got %0d R%b want 19 R1", Count, Right); end
        cw();
        tests++; if (Count !== 5'd0) begin fails++; $display("FAIL wrap_up: got %0d want 0", Count); end
        ccw();
        tests++; if (Count !== 5'd0 || Left !== 1'b1 || Right !== 1'b0) begin
            fails++; $display("FAIL wrap_reversal: got %0d R%b L%b want 0 R0 L1", Count, Right, Left); end
        ccw();
        tests++; if (Count !== 5'd19 || Left !== 1'b1) begin fails++; $display("FAIL wrap_down: got %0d L%b want 19 L1", Count, Left); end
    endtask

    task automatic test_reversal();
        int s0;
        do_reset();
        for (int i = 0; i < 13; i++) cw();
        tests++; if (Count !== 5'd13) begin fails++; $display("FAIL rev_dial: got %0d want 13", Count); end
        s0 = step_seen;
        ccw();
        tests++; if (Count !== 5'd13 || Left !== 1'b1 || Right !== 1'b0) begin
            fails++; $display("FAIL rev_ccw: got %0d R%b L%b want 13 R0 L1", Count, Right, Left); end
        tests++; if (step_seen - s0 != 1) begin fails++; $display("FAIL rev_step: got %0d want 1", step_seen - s0); end
        cw();
        tests++; if (Count !== 5'd13 || Right !== 1'b1 || Left !== 1'b0) begin
            fails++; $display("FAIL rev_cw: got %0d R%b L%b want 13 R1 L0", Count, Right, Left); end
    endtask

    task automatic test_bounce();
        int s0;
        s0 = step_seen;
        for (int k = 0; k < 4; k++) begin drive(2'b01, 3); drive(2'b11, LONG); end
        drive(2'b01, LONG); drive(2'b11, LONG);
        drive(2'b01, LONG); drive(2'b00, LONG); drive(2'b10, LONG);
        drive(2'b11, 3); drive(2'b10, LONG);
        tests++; if (step_seen != s0 || Count !== 5'd13) begin
            fails++; $display("FAIL bounce_ignored: got steps %0d count %0d want 0 13", step_seen - s0, Count); end
        drive(2'b11, D); drive(2'b10, LONG);
        tests++; if (step_seen - s0 != 1 || Count !== 5'd14) begin
            fails++; $display("FAIL bounce_min_width: got steps %0d count %0d want 1 14", step_seen - s0, Count); end
        drive(2'b11, LONG);
        drive(2'b01, D); drive(2'b00, D); drive(2'b10, D); drive(2'b11, LONG);
        tests++; if (step_seen - s0 != 2 || Count !== 5'd15) begin
            fails++; $display("FAIL exact_width_detent: got steps %0d count %0d want 2 15", step_seen - s0, Count); end
    endtask

    task automatic test_illegal();
        int s0;
        s0 = step_seen;
        drive(2'b00, LONG); drive(2'b11, LONG);
        drive(2'b01, LONG); drive(2'b10, LONG); drive(2'b11, LONG);
        tests++; if (step_seen != s0 || Count !== 5'd15 || Right !== 1'b1) begin
            fails++; $display("FAIL illegal_no_detent: got steps %0d count %0d R%b want 0 15 R1", step_seen - s0, Count, Right); end
        cw();
        tests++; if (Count !== 5'd16) begin fails++; $display("FAIL illegal_back_to_rest: got %0d want 16", Count); end
    endtask

    task automatic test_clear_detent();
        int s0;
        drive(2'b01, LONG); drive(2'b00, LONG); drive(2'b10, LONG);
        s0 = step_seen;
        {RotA, RotB} = 2'b11;
        repeat (6) @(posedge Clk);
        #1 Clear = 1'b1;
        @(posedge Clk);
        #1 Clear = 1'b0;
        tests++; if (Count !== 5'd0 || Right !== 1'b0 || Left !== 1'b0 || Step !== 1'b0) begin
            fails++; $display("FAIL clear_detent: got %0d R%b L%b S%b want 0 R0 L0 S0", Count, Right, Left, Step); end
        repeat (LONG) @(posedge Clk);
        #1;
        tests++; if (step_seen != s0) begin fails++; $display("FAIL clear_step: got %0d want 0", step_seen - s0); end
        m_lvl = 2'b11; m_off = 0; m_cnt = 0; m_r = 1'b0; m_l = 1'b0;
        cw();
        tests++; if (Count !== 5'd1 || Right !== 1'b1) begin fails++; $display("FAIL clear_then_cw: got %0d R%b want 1 R1", Count, Right); end
    endtask

    task automatic test_reset_mid();
        drive(2'b01, LONG); drive(2'b00, LONG);
        #2 ResetN = 1'b0;
        #1;
        tests++; if (Count !== 5'd0 || Right !== 1'b0 || Left !== 1'b0 || Step !== 1'b0) begin
            fails++; $display("FAIL reset_async: got %0d R%b L%b S%b want 0 R0 L0 S0", Count, Right, Left, Step); end
        repeat (2) @(posedge Clk);
        #1 ResetN = 1'b1;
        model_reset();
        m_steps = step_seen;
        drive(2'b00, LONG); drive(2'b11, LONG);
        cw();
        tests++; if (Count !== 5'd1 || Right !== 1'b1 || Left !== 1'b0) begin
            fails++; $display("FAIL reset_then_cw: got %0d R%b L%b want 1 R1 L0", Count, Right, Left); end
    endtask

    task automatic test_random();
        int r, hold, g;
        bit last_long;
        logic [1:0] blvl;
        do_reset();
        last_long = 1'b1;
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 99));
            if (!last_long && r >= 80) r = r - 80;
            g = gidx(m_lvl);
            if (r >= 90) begin
                #1 Clear = 1'b1;
                @(posedge Clk);
                #1 Clear = 1'b0;
                m_cnt = 0; m_r = 1'b0; m_l = 1'b0;
                drive(m_lvl, LONG);
            end else if (r >= 80) begin
                blvl = m_lvl ^ (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
                drive(blvl, int'($urandom_range(1, D - 1)));
                drive(m_lvl, LONG);
            end else begin
                hold = ($urandom_range(0, 1) == 1) ? int'($urandom_range(D, D + 2)) : int'($urandom_range(LONG, LONG + 4));
                if (r < 40) drive(lvl_of(g + 1), hold);
                else if (r < 70) drive(lvl_of(g + 3), hold);
                else drive(lvl_of(g + 2), hold);
                last_long = (hold >= LONG);
                if (!last_long) continue;
            end
            last_long = 1'b1;
            tests++; if (Count !== 5'(m_cnt)) begin fails++; $display("FAIL rand_count[%0d]: got %0d want %0d", n, Count, m_cnt); end
            tests++; if (Right !== m_r || Left !== m_l) begin
                fails++; $display("FAIL rand_flags[%0d]: got R%b L%b want R%b L%b", n, Right, Left, m_r, m_l); end
            tests++; if (step_seen != m_steps) begin fails++; $display("FAIL rand_steps[%0d]: got %0d want %0d", n, step_seen, m_steps); end
        end
    endtask

    initial begin
        ResetN = 1'b1; RotA = 1'b1; RotB = 1'b1; Clear = 1'b0;
        model_reset();
        m_steps = 0;
        test_reset();
        test_cw_latency();
        test_wrap();
        test_reversal();
        test_bounce();
        test_illegal();
        test_clear_detent();
        test_reset_mid();
        test_random();
        tests++; if (both_seen != 0) begin fails++; $display("FAIL flags_exclusive: got %0d cycles with both set want 0", both_seen); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
